// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Serial-to-parallel receive front end for the UART user project, 8N1 only.
//   The rx pin goes through a metastability synchroniser. The start bit is
//   re-checked at half a bit period. The eight data bits are then sampled
//   LSB-first at mid-bit, and the stop bit decides between a good byte and a
//   framing error.
//
// Ports
//   clk       system clock (wb_clk_i at top level)
//   rst_n     asynchronous active-low reset
//   clk_div   clock cycles per bit; values below 4 are treated as 4
//   rx        asynchronous serial line, idle high
//   rx_data   last good byte, held until the next good byte
//   rx_valid  one-cycle strobe: rx_data holds a new good byte (FIFO push)
//   frame_err one-cycle strobe: stop bit was sampled low
//   busy      high whenever a frame is in progress or a break is being waited out
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | line idle, waiting for rx_s low
// ST_START   | counting half a bit, then re-checking the start bit
// ST_DATA    | sampling 8 data bits at mid-bit, LSB first
// ST_STOP    | sampling the stop bit one bit period after data bit 7
// ST_WAIT_HIGH | framing error seen; wait for the line to return high

module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clk_div,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] d_q, d_d;
  logic [31:0] h_q, h_d;
  logic [7:0]  data_d;
  logic        valid_d;
  logic        err_d;
  logic [31:0] d_lat;

  // Synchroniser flops reset to the idle level so that reset never looks
  // like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Very small dividers would leave no room for a half-bit start check.
  assign d_lat = (clk_div < 32'd4) ? 32'd4 : clk_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      d_q       <= 32'd4;
      h_q       <= 32'd2;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      d_q       <= d_d;
      h_q       <= h_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    d_d     = d_q;
    h_d     = h_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          // The divider is frozen for the whole frame.
          d_d     = d_lat;
          h_d     = d_lat >> 1;
        end
      end

      ST_START: begin
        if (cnt_q == h_q - 32'd1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_DATA: begin
        if (cnt_q == d_q - 32'd1) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_STOP: begin
        if (cnt_q == d_q - 32'd1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
//   Bench for uart_rx_sampler. A reference model predicts rx_valid,
//   frame_err, rx_data and busy from the recorded line history. It uses
//   absolute sample offsets measured from the edge where the start bit is
//   first seen. A negedge process compares the DUT against the model on
//   every cycle. Each directed scenario also pins strobe timing and data
//   with hand-computed constants.

module tb_uart_rx_sampler;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] clk_div = 32'd16;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_sampler #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_div   (clk_div),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, got, got, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit       line[$];
  int       first_ok = 0;
  int       m_mode = 0;
  int       m_p, m_d, m_h;
  bit [7:0] m_bits;
  bit [7:0] m_data = 8'h00;
  bit       m_valid = 1'b0;
  bit       m_err = 1'b0;
  bit       m_busy = 1'b0;

  // The line level seen by the receiver logic at active edge n. This is the
  // pin value captured SYNC edges earlier. Before that, the synchroniser
  // still holds its reset value, which is high.
  function automatic bit rxs_at(input int n);
    if (n - SYNC < first_ok) return 1'b1;
    return line[n - SYNC];
  endfunction

  task automatic model_step(input int n);
    bit rs;
    int off, k;
    rs      = rxs_at(n);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (m_mode == 0) begin
      if (!rs) begin
        m_mode = 1;
        m_p    = n;
        m_d    = (clk_div < 4) ? 4 : int'(clk_div);
        m_h    = m_d / 2;
      end
    end else if (m_mode == 1) begin
      off = n - m_p;
      if (off == m_h) begin
        if (rs) m_mode = 0;
      end else if (off > m_h && ((off - m_h) % m_d) == 0) begin
        k = (off - m_h) / m_d;
        if (k <= 8) begin
          m_bits[k-1] = rs;
        end else begin
          if (rs) begin
            m_data  = m_bits;
            m_valid = 1'b1;
            m_mode  = 0;
          end else begin
            m_err  = 1'b1;
            m_mode = 2;
          end
        end
      end
    end else begin
      if (rs) m_mode = 0;
    end
    m_busy = (m_mode != 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   = 0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_data   = 8'h00;
      m_busy   = 1'b0;
      first_ok = line.size();
    end else begin
      line.push_back(rx);
      model_step(line.size() - 1);
    end
  end

  // ------------------------------------------------- compare and monitor
  int       v_edge[$];
  bit [7:0] v_data[$];
  bit       v_busy[$];
  int       e_edge[$];
  int       run = 0;
  int       maxrun = 0;

  always @(negedge clk) begin
    check("rx_valid", rx_valid, m_valid);
    check("frame_err", frame_err, m_err);
    check("busy", busy, m_busy);
    check("rx_data", rx_data, m_data);
    if (rx_valid) begin
      v_edge.push_back(line.size() - 1);
      v_data.push_back(rx_data);
      v_busy.push_back(busy);
    end
    if (frame_err) e_edge.push_back(line.size() - 1);
    if (busy) begin
      run++;
    end else begin
      if (run > maxrun) maxrun = run;
      run = 0;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    v_edge.delete();
    v_data.delete();
    v_busy.delete();
    e_edge.delete();
    maxrun = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input int d, input bit stop_bit,
                            input int chg_lvl, input logic [31:0] chg_val);
    for (int i = 0; i < 10; i++) begin
      if (i == chg_lvl) clk_div = chg_val;
      rx = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
      repeat (d) tick();
    end
  endtask

  int       e0;
  int       n_good, n_bad;
  int       rd, rde, rchg;
  bit       rstop;
  logic [7:0] rb;
  logic [7:0] b5a;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    clk_div = 32'd16;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    idle_ticks(32);

    // Single good frame at D=16.
    clear_mon();
    e0 = line.size();
    send_frame(8'hA5, 16, 1'b1, -1, 32'd0);
    idle_ticks(32);
    check("t1_valid_count", v_edge.size(), 1);
    check("t1_err_count", e_edge.size(), 0);
    if (v_edge.size() > 0) begin
      check("t1_stop_edge", v_edge[0] - e0, 154);
      check("t1_data", v_data[0], 8'hA5);
      check("t1_busy_at_strobe", v_busy[0], 1'b0);
    end

    // Three-cycle glitch: rejected at the start-bit check.
    clear_mon();
    rx = 1'b0;
    repeat (3) tick();
    idle_ticks(48);
    check("t2_valid_count", v_edge.size(), 0);
    check("t2_err_count", e_edge.size(), 0);
    check("t2_busy_run_ok", (maxrun > 0 && maxrun <= 9), 1);
    check("t2_data_held", rx_data, 8'hA5);

    // Break of 20 bit times, then a good frame.
    clear_mon();
    e0 = line.size();
    rx = 1'b0;
    repeat (320) tick();
    check("t3_busy_in_break", busy, 1'b1);
    check("t3_err_count", e_edge.size(), 1);
    if (e_edge.size() > 0) check("t3_err_edge", e_edge[0] - e0, 154);
    idle_ticks(32);
    send_frame(8'h3C, 16, 1'b1, -1, 32'd0);
    idle_ticks(32);
    check("t3_valid_count", v_edge.size(), 1);
    if (v_data.size() > 0) check("t3_data", v_data[0], 8'h3C);
    check("t3_err_final", e_edge.size(), 1);

    // Back-to-back frames with no idle gap.
    clear_mon();
    e0 = line.size();
    send_frame(8'h00, 16, 1'b1, -1, 32'd0);
    send_frame(8'hFF, 16, 1'b1, -1, 32'd0);
    send_frame(8'h55, 16, 1'b1, -1, 32'd0);
    idle_ticks(32);
    check("t4_valid_count", v_edge.size(), 3);
    if (v_edge.size() == 3) begin
      check("t4_edge0", v_edge[0] - e0, 154);
      check("t4_gap01", v_edge[1] - v_edge[0], 160);
      check("t4_gap12", v_edge[2] - v_edge[1], 160);
      check("t4_data0", v_data[0], 8'h00);
      check("t4_data1", v_data[1], 8'hFF);
      check("t4_data2", v_data[2], 8'h55);
    end

    // clk_div below the floor behaves as D=4.
    clk_div = 32'd2;
    clear_mon();
    e0 = line.size();
    send_frame(8'h96, 4, 1'b1, -1, 32'd0);
    idle_ticks(16);
    check("t5_valid_count", v_edge.size(), 1);
    if (v_edge.size() > 0) begin
      check("t5_stop_edge", v_edge[0] - e0, 40);
      check("t5_data", v_data[0], 8'h96);
    end

    // Odd divider: D=17, H=8.
    clk_div = 32'd17;
    clear_mon();
    e0 = line.size();
    send_frame(8'h81, 17, 1'b1, -1, 32'd0);
    idle_ticks(34);
    check("t6_valid_count", v_edge.size(), 1);
    if (v_edge.size() > 0) begin
      check("t6_stop_edge", v_edge[0] - e0, 163);
      check("t6_data", v_data[0], 8'h81);
    end

    // clk_div changed during data bit 3 must not disturb the frame.
    clk_div = 32'd16;
    clear_mon();
    e0 = line.size();
    send_frame(8'hC3, 16, 1'b1, 4, 32'd5);
    idle_ticks(32);
    clk_div = 32'd16;
    check("t7_valid_count", v_edge.size(), 1);
    if (v_edge.size() > 0) begin
      check("t7_stop_edge", v_edge[0] - e0, 154);
      check("t7_data", v_data[0], 8'hC3);
    end

    // Reset pulsed during data bit 4, then a clean 0x5A frame.
    clear_mon();
    b5a = 8'h5A;
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      repeat (16) tick();
    end
    rx = b5a[4];
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_ticks(48);
    check("t8_valid_count", v_edge.size(), 0);
    check("t8_err_count", e_edge.size(), 0);
    check("t8_data_reset", rx_data, 8'h00);
    check("t8_busy", busy, 1'b0);
    e0 = line.size();
    send_frame(8'h5A, 16, 1'b1, -1, 32'd0);
    idle_ticks(32);
    check("t8_valid_after", v_edge.size(), 1);
    if (v_edge.size() > 0) begin
      check("t8_stop_edge", v_edge[0] - e0, 154);
      check("t8_data", v_data[0], 8'h5A);
    end

    // Randomized frames: divider, data, stop level, gap and mid-frame
    // divider changes.
    clear_mon();
    n_good = 0;
    n_bad  = 0;
    for (int f = 0; f < 40; f++) begin
      rd    = $urandom_range(2, 24);
      rde   = (rd < 4) ? 4 : rd;
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      rchg  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1;
      clk_div = 32'(rd);
      send_frame(rb, rde, rstop, rchg, 32'($urandom_range(2, 30)));
      if (rstop) begin
        n_good++;
        idle_ticks($urandom_range(0, 2) * rde);
      end else begin
        n_bad++;
        idle_ticks(2 * rde);
      end
    end
    idle_ticks(64);
    check("rand_valid_count", v_edge.size(), n_good);
    check("rand_err_count", e_edge.size(), n_bad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial-to-parallel UART receive front end. It sits between the `rx` pad input (`io_in[5]`) and the RX FIFO push port inside the UART user project. It synchronises the pin, validates the start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit, then emits a one-cycle `rx_valid` strobe with the byte, or a one-cycle `frame_err` strobe. The format is fixed 8N1; the bit period comes from the same `clk_div` word (clock frequency / baud) the UART top already computes.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: depth of the `rx` metastability synchroniser; legal values are 2 or 3.

Ports:
- `clk` input 1: system clock (`wb_clk_i` at top level).
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `clk_div` input 32: clock cycles per bit (D).
- `rx` input 1: asynchronous serial line; idle level is high.
- `rx_data` output 8: last good byte, held until the next good byte.
- `rx_valid` output 1: one-cycle strobe, byte good; wired to FIFO `push`.
- `frame_err` output 1: one-cycle strobe, stop bit sampled low.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
Synchroniser:
- `rx` passes through `SYNC_STAGES` flops, all reset to 1. The output is `rx_s`.
- All decisions use `rx_s` only.

Divider handling:
- On entry to START, latch `D = max(clk_div, 4)` and `H = D >> 1`.
- Changes to `clk_div` mid-frame are ignored until the next frame.

States:
- IDLE: when `rx_s == 0`, go to START and clear `cnt`.
- START:
  - `cnt` increments each cycle.
  - At `cnt == H-1`: if `rx_s == 0`, go to DATA with `cnt = 0` and `idx = 0`.
  - Otherwise go to IDLE (glitch rejected, no strobe).
- DATA:
  - `cnt` increments.
  - At `cnt == D-1`: `shift[idx] <= rx_s`, `idx++`, `cnt = 0`.
  - After `idx == 7` is sampled, go to STOP.
- STOP:
  - At `cnt == D-1`: if `rx_s == 1`, set `rx_data <= shift`, pulse `rx_valid`, and go to IDLE.
  - If `rx_s == 0`, pulse `frame_err`, leave `rx_data` unchanged, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s == 1`, then go to IDLE. A break condition must never be treated as a start bit.

Counter and index widths:
- `cnt` is 32 bits and `idx` is 3 bits.
- No wrap-around occurs within a legal frame.

Output rules:
- `rx_valid` and `frame_err` are registered, mutually exclusive, and never high for more than one cycle.
- `busy` is combinational from state: high in START, DATA, STOP and WAIT_HIGH.

Reset:
- `rst_n` low at any time (including mid-frame) forces IDLE and clears `cnt`, `idx` and `shift`.
- Reset values: `rx_data = 8'h00`, `rx_valid = 0`, `frame_err = 0`, `busy = 0`.
- A partial frame produces no strobe.

## Timing
- Let E0 be the clock edge at which the first synchroniser flop captures `rx` low.
- With `SYNC_STAGES = 2`, IDLE sees `rx_s == 0` at E2. Add 1 edge per extra stage.
- Sample edges:
  - Start-bit check at E(2+H).
  - Data bit k (k = 0..7) at E(2+H+(k+1)·D).
  - Stop bit at E(2+H+9·D).
- `rx_valid`/`frame_err` are high for exactly the one cycle following the stop-sample edge. `rx_data` is valid in that cycle and afterwards.
- After a good frame, the state is IDLE immediately after the stop sample. A following start bit arriving roughly H cycles later is caught with no loss.
- Back-to-back frames with no idle gap, driven clock-aligned, produce strobes spaced exactly 10·D cycles apart.
- Odd D: H = floor(D/2), e.g. D = 17 gives H = 8.

## Test plan
- `clk_div = 16`, frame 0xA5 with stop = 1, edge-aligned: exactly one `rx_valid` in the cycle after E154 (2+8+144), `rx_data = 8'hA5`, `frame_err` stays 0, `busy` falls the same cycle.
- `clk_div = 16`, `rx` low for 3 cycles then high: `busy` high for ≤ 9 cycles then low, no `rx_valid`/`frame_err`, `rx_data` unchanged.
- `clk_div = 16`, `rx` held low for 20 bit times, then frame 0x3C: one `frame_err`; `busy` stays high until `rx` returns high; then one `rx_valid` with `8'h3C`; no spurious frames.
- `clk_div = 16`, three frames 0x00, 0xFF, 0x55 with no idle gap: three `rx_valid` strobes 160 cycles apart, with data matching in order.
- Divider edge cases:
  - `clk_div = 2`: behaves as D = 4 (stop sample at E2+2+36).
  - `clk_div = 17`: 0x81 received with H = 8.
  - `clk_div` changed mid-frame: no effect on the current frame.
- Reset mid-frame: `rst_n` pulsed low during DATA bit 4. All outputs return to reset values, no strobe occurs, and the next 0x5A frame is received correctly.
